lsu: RTL and testbench
======================

# lsu

Load/store unit: the initiator side of the data-memory port. Accepts one load or store at a time from the execute stage over a valid/ready handshake and drives the `dmem` port (`address`, `write_data`, `width`, `read_enable`, `write_enable`, `read_data`). Completes each request with a response carrying load data and an error flag. Misaligned accesses are split into sequential byte beats, and load results are assembled and sign- or zero-extended.

## Interface
- `SPLIT_MISALIGNED`, default 1. When 1, misaligned accesses are split into byte beats. When 0, they complete with `resp_err`=1 and make no memory access.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted on an edge where `req_valid` and `req_ready` are both 1.
- `req_store` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RISC-V funct3 (loads 000/001/010/100/101; stores 000/001/010).
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data (low byte/half/word used).
- `resp_valid` out 1: response present.
- `resp_ready` in 1: response consumed on an edge where `resp_valid` and `resp_ready` are both 1.
- `resp_rdata` out 32: extended load result; 0 for stores and errors.
- `resp_err` out 1: illegal funct3, or misaligned access with `SPLIT_MISALIGNED`=0.
- `address` out 32: to `dmem`.
- `write_data` out 32: to `dmem`.
- `width` out 3: to `dmem`, funct3 encoding.
- `read_enable` out 1: to `dmem`.
- `write_enable` out 1: to `dmem`.
- `read_data` in 32: from `dmem`; combinational read, valid in the same cycle as `read_enable`.

## Operation
- States are IDLE, ACCESS and RESP. `req_ready` = (state == IDLE) and not `reset`.
- **IDLE, on accept:**
  - Latch op, address and data.
  - Compute the beat count: 1 if aligned; 2 for a misaligned half (addr[0]=1); 4 for a misaligned word (addr[1:0]≠0).
  - Go to ACCESS, or go straight to RESP with `resp_err`=1 for an illegal funct3 (load 011/110/111, store ≥011) or a disallowed misaligned access.
- **ACCESS, aligned (1 beat):**
  - `address` = addr, `width` = funct3.
  - `write_data` = `req_wdata`, `write_enable` = `req_store`, `read_enable` = !`req_store`.
- **ACCESS, split beat k (k = 0..N-1):**
  - `address` = addr + k, 32-bit wrap-around.
  - `width` = 100 for loads, 000 for stores.
  - `write_data` = {24'b0, wdata[8k+7:8k]}.
  - Load byte k is taken from `read_data[7:0]` into assembly byte k (little-endian).
- After the last beat, go to RESP.
- **Load result:** assembled/returned value extended per funct3. 000 and 001 sign-extend from bit 7 and bit 15 respectively; 100 and 101 zero-extend; 010 passes through.
- **RESP:** `resp_valid`=1. All outputs are held stable while `resp_ready`=0. On handshake, go to IDLE; a new request cannot be accepted in the same cycle.
- Exactly one `dmem` enable is high per ACCESS cycle; both are 0 in IDLE and RESP.
- **Reset mid-operation:** return to IDLE on the next edge. Already-written store beats are not rolled back, and no response is issued for the aborted request.

## Timing
- Reset values:
  - state IDLE.
  - `resp_valid` 0, `resp_rdata` 0, `resp_err` 0.
  - `read_enable` 0, `write_enable` 0.
  - `address` 0, `write_data` 0, `width` 000.
- `dmem` drive signals are registered.
- Accept on edge E0. Beat k is driven during cycle E0+1+k, and `read_data` is sampled at its ending edge.
- `resp_valid` rises at E0+1+N: aligned E0+2, misaligned half E0+3, misaligned word E0+5.
- Error requests: `resp_valid` at E0+1, with no enable ever asserted.
- Throughput: one request per N+2 cycles at best.

## Structure
- `lsu_pkg` holds:
  - funct3 constants `F3_B`/`F3_H`/`F3_W`/`F3_BU`/`F3_HU`;
  - the state enum `lsu_state_t`;
  - the function `beats_for(funct3, addr[1:0])`.
- One sub-module, `load_align`: a combinational block taking the assembled 32-bit value and funct3 and producing the extended result.

## Test plan
Bench pairs `lsu` with the existing `dmem`.
- **Store then read back:** SW 0x000000F0 @4, then LBU @4 → one write beat (addr 4, width 010); `resp_rdata`=0x000000F0 at E0+2.
- **Sign vs zero extension:** SB 0x80 @8; LB @8 → 0xFFFFFF80; LBU @8 → 0x00000080; LH @8 after SH 0x8001 → 0xFFFF8001.
- **Misaligned load:** memory bytes 4..9 = 11 22 33 44 55 66; LW @5 → beats at addr 5,6,7,8 with width 100; `resp_rdata`=0x55443322 at E0+5.
- **Misaligned store:** SH 0xBEEF @3 → beats (addr 3, data 0xEF) then (addr 4, data 0xBE), width 000; LHU @3 → 0x0000BEEF.
- **Errors and backpressure:**
  - Load funct3 011 → `resp_err`=1, `resp_rdata`=0, no enable asserted.
  - Hold `resp_ready`=0 for 3 cycles → response stable and `req_ready`=0 throughout.
  - With `SPLIT_MISALIGNED`=0, LW @2 → `resp_err`=1 at E0+1.
- **Reset mid-operation:** assert `reset` during beat 2 of SW @1 → enables 0 and state IDLE after the next edge; no `resp_valid`; `req_ready`=1 after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states,
// and the request decode helpers used when a request is accepted.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_t;

  // Number of memory beats for an access: one when naturally aligned,
  // otherwise one byte beat per byte of the access.
  function automatic logic [2:0] beats_for(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic [2:0] beats;
    beats = 3'd1;
    case (funct3)
      F3_H, F3_HU: beats = addr_lo[0] ? 3'd2 : 3'd1;
      F3_W:        beats = (addr_lo != 2'b00) ? 3'd4 : 3'd1;
      default:     beats = 3'd1;
    endcase
    return beats;
  endfunction

  // Loads accept B/H/W/BU/HU; stores accept only B/H/W.
  function automatic logic illegal_funct3(input logic store, input logic [2:0] funct3);
    if (store) begin
      return funct3 > F3_W;
    end
    return (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response channel between execute and the LSU, and the
// data-memory port driven by the LSU.
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

interface dmem_if;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [2:0]  width;
  logic        read_enable;
  logic        write_enable;
  logic [31:0] read_data;

  modport master (
    output address, write_data, width, read_enable, write_enable,
    input  read_data
  );

  modport slave (
    input  address, write_data, width, read_enable, write_enable,
    output read_data
  );
endinterface

// File: rtl/lsu_load_align.sv
// Extends an assembled little-endian load value according to funct3.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  // Sign- or zero-extend the low byte/half; words pass through.
  always_comb begin
    result = raw;
    case (funct3)
      F3_B:    result = {{24{raw[7]}}, raw[7:0]};
      F3_H:    result = {{16{raw[15]}}, raw[15:0]};
      F3_BU:   result = {24'b0, raw[7:0]};
      F3_HU:   result = {16'b0, raw[15:0]};
      default: result = raw;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one request at a time, drives registered
// data-memory beats (splitting misaligned accesses into byte beats),
// and returns an extended load result plus an error flag.
module lsu
  import lsu_pkg::*;
#(
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input logic    clk,
  input logic    reset,
  lsu_if.slave   cpu,
  dmem_if.master dmem
);

  lsu_state_t  state_reg;
  logic        store_reg;
  logic [2:0]  funct3_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [2:0]  beats_reg;
  logic [1:0]  beat_idx_reg;
  logic [31:0] asm_reg;

  logic        resp_valid_reg;
  logic        resp_err_reg;
  logic [31:0] resp_rdata_reg;
  logic [31:0] address_reg;
  logic [31:0] write_data_reg;
  logic [2:0]  width_reg;
  logic        read_enable_reg;
  logic        write_enable_reg;

  logic [2:0]  req_beats;
  logic        req_split;
  logic        req_reject;
  logic [1:0]  next_idx;
  logic        last_beat;
  logic [7:0]  next_byte;
  logic [31:0] asm_next;
  logic [31:0] load_result;

  assign req_beats  = beats_for(cpu.req_funct3, cpu.req_addr[1:0]);
  assign req_split  = (req_beats != 3'd1);
  assign req_reject = illegal_funct3(cpu.req_store, cpu.req_funct3) ||
                      (!SPLIT_MISALIGNED && req_split);
  assign next_idx   = beat_idx_reg + 2'd1;
  assign last_beat  = (({1'b0, beat_idx_reg} + 3'd1) == beats_reg);
  assign next_byte  = wdata_reg[{next_idx, 3'b000} +: 8];

  // Merge this cycle's read data into the assembly register: whole word for
  // a single beat, otherwise byte k of the split access.
  always_comb begin
    asm_next = asm_reg;
    if (beats_reg == 3'd1) begin
      asm_next = dmem.read_data;
    end else begin
      asm_next[{beat_idx_reg, 3'b000} +: 8] = dmem.read_data[7:0];
    end
  end

  load_align u_load_align (
    .raw    (asm_next),
    .funct3 (funct3_reg),
    .result (load_result)
  );

  // Request FSM with registered memory drive and response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= IDLE;
      store_reg        <= 1'b0;
      funct3_reg       <= 3'b000;
      addr_reg         <= 32'h0;
      wdata_reg        <= 32'h0;
      beats_reg        <= 3'd1;
      beat_idx_reg     <= 2'd0;
      asm_reg          <= 32'h0;
      resp_valid_reg   <= 1'b0;
      resp_err_reg     <= 1'b0;
      resp_rdata_reg   <= 32'h0;
      address_reg      <= 32'h0;
      write_data_reg   <= 32'h0;
      width_reg        <= 3'b000;
      read_enable_reg  <= 1'b0;
      write_enable_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cpu.req_valid) begin
            store_reg    <= cpu.req_store;
            funct3_reg   <= cpu.req_funct3;
            addr_reg     <= cpu.req_addr;
            wdata_reg    <= cpu.req_wdata;
            beats_reg    <= req_beats;
            beat_idx_reg <= 2'd0;
            asm_reg      <= 32'h0;
            if (req_reject) begin
              // Rejected requests never touch memory.
              state_reg      <= RESP;
              resp_valid_reg <= 1'b1;
              resp_err_reg   <= 1'b1;
              resp_rdata_reg <= 32'h0;
            end else begin
              // Beat 0 is driven in the cycle right after acceptance.
              state_reg        <= ACCESS;
              address_reg      <= cpu.req_addr;
              read_enable_reg  <= !cpu.req_store;
              write_enable_reg <= cpu.req_store;
              if (req_split) begin
                width_reg      <= cpu.req_store ? F3_B : F3_BU;
                write_data_reg <= {24'b0, cpu.req_wdata[7:0]};
              end else begin
                width_reg      <= cpu.req_funct3;
                write_data_reg <= cpu.req_wdata;
              end
            end
          end
        end
        ACCESS: begin
          asm_reg      <= asm_next;
          beat_idx_reg <= next_idx;
          if (last_beat) begin
            state_reg        <= RESP;
            resp_valid_reg   <= 1'b1;
            resp_err_reg     <= 1'b0;
            resp_rdata_reg   <= store_reg ? 32'h0 : load_result;
            read_enable_reg  <= 1'b0;
            write_enable_reg <= 1'b0;
          end else begin
            address_reg    <= addr_reg + {30'b0, next_idx};
            write_data_reg <= {24'b0, next_byte};
          end
        end
        RESP: begin
          if (cpu.resp_ready) begin
            state_reg      <= IDLE;
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            resp_rdata_reg <= 32'h0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign cpu.req_ready  = (state_reg == IDLE) && !reset;
  assign cpu.resp_valid = resp_valid_reg;
  assign cpu.resp_err   = resp_err_reg;
  assign cpu.resp_rdata = resp_rdata_reg;

  assign dmem.address      = address_reg;
  assign dmem.write_data   = write_data_reg;
  assign dmem.width        = width_reg;
  assign dmem.read_enable  = read_enable_reg;
  assign dmem.write_enable = write_enable_reg;

endmodule

// File: tb/tb_lsu.sv
// Testbench for lsu: directed table, hand-written corner sequences and
// randomized traffic checked against a byte-array memory model.
module tb_lsu;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic mem_load;
  always #5 clk = ~clk;

  lsu_if  cpu ();
  dmem_if dm ();
  lsu_if  cpu_ns ();
  dmem_if dm_ns ();

  lsu #(.SPLIT_MISALIGNED(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .cpu   (cpu),
    .dmem  (dm)
  );

  lsu #(.SPLIT_MISALIGNED(1'b0)) dut_ns (
    .clk   (clk),
    .reset (reset),
    .cpu   (cpu_ns),
    .dmem  (dm_ns)
  );

  // Data memory stand-in: 256 bytes, combinational little-endian read,
  // write of 1/2/4 bytes selected by width.
  logic [7:0] mem [256];
  logic [7:0] init_mem [256];
  logic [7:0] ref_mem [256];
  logic [7:0] a8;
  assign a8 = dm.address[7:0];
  assign dm.read_data = {mem[a8 + 8'd3], mem[a8 + 8'd2], mem[a8 + 8'd1], mem[a8]};
  assign dm_ns.read_data = 32'h0;

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_mem[i];
    end else if (dm.write_enable) begin
      mem[a8] <= dm.write_data[7:0];
      if (dm.width[1:0] != 2'b00) mem[a8 + 8'd1] <= dm.write_data[15:8];
      if (dm.width[1:0] == 2'b10) begin
        mem[a8 + 8'd2] <= dm.write_data[23:16];
        mem[a8 + 8'd3] <= dm.write_data[31:24];
      end
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit is_illegal(input bit st, input logic [2:0] f3);
    if (st) return f3 > 3'd2;
    return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    logic [7:0]  idx;
    v = 32'h0;
    for (int i = 0; i < size_of(f3); i++) begin
      idx = a[7:0] + 8'(i);
      v = v | (32'(ref_mem[idx]) << (8 * i));
    end
    if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
    if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    logic [7:0] idx;
    for (int i = 0; i < size_of(f3); i++) begin
      idx = a[7:0] + 8'(i);
      ref_mem[idx] = 8'(wd >> (8 * i));
    end
  endtask

  // ---------------- one transaction ----------------
  task automatic do_txn(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input bit use_exp, input logic [31:0] exp_rd,
                        input bit exp_er, input int exp_nb, input int hold, input string tag);
    int n, nb, nbeats, cyc;
    bit ill, split;
    logic [31:0] exp_rdata, got_rdata;
    logic [31:0] b_addr [8];
    logic [31:0] b_width [8];
    logic [31:0] b_wdata [8];
    logic        b_we [8];
    logic [31:0] e_addr, e_width, e_wdata;

    ill       = is_illegal(st, f3);
    n         = size_of(f3);
    split     = !ill && ((int'(a[1:0]) % n) != 0);
    nbeats    = ill ? 0 : (split ? n : 1);
    exp_rdata = (ill || st) ? 32'h0 : ref_load(f3, a);

    cyc = 0;
    while (!cpu.req_ready && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, " req_ready"}, 32'(cpu.req_ready), 32'd1);

    cpu.req_valid  = 1'b1;
    cpu.req_store  = st;
    cpu.req_funct3 = f3;
    cpu.req_addr   = a;
    cpu.req_wdata  = wd;
    @(posedge clk); #1;
    cpu.req_valid = 1'b0;

    nb  = 0;
    cyc = 1;
    while (!cpu.resp_valid && cyc <= 12) begin
      if (dm.read_enable && dm.write_enable) check({tag, " both enables"}, 32'd1, 32'd0);
      if (dm.read_enable || dm.write_enable) begin
        if (nb < 8) begin
          b_addr[nb]  = dm.address;
          b_width[nb] = 32'(dm.width);
          b_wdata[nb] = dm.write_data;
          b_we[nb]    = dm.write_enable;
        end
        nb++;
      end
      @(posedge clk); #1;
      cyc++;
    end

    check({tag, " resp latency"}, 32'(cyc), 32'(1 + nbeats));
    check({tag, " beat count"}, 32'(nb), 32'(nbeats));
    for (int i = 0; i < nb && i < nbeats && i < 8; i++) begin
      e_addr  = split ? a + 32'(i) : a;
      e_width = split ? (st ? 32'd0 : 32'd4) : 32'(f3);
      e_wdata = split ? 32'(8'(wd >> (8 * i))) : wd;
      check({tag, " beat addr"}, b_addr[i], e_addr);
      check({tag, " beat width"}, b_width[i], e_width);
      check({tag, " beat we"}, 32'(b_we[i]), 32'(st));
      if (st) check({tag, " beat wdata"}, b_wdata[i], e_wdata);
    end
    check({tag, " resp_valid"}, 32'(cpu.resp_valid), 32'd1);
    check({tag, " resp_err"}, 32'(cpu.resp_err), 32'(ill));
    check({tag, " resp_rdata"}, cpu.resp_rdata, exp_rdata);
    check({tag, " enables in resp"}, 32'({dm.read_enable, dm.write_enable}), 32'd0);
    if (use_exp) begin
      check({tag, " table rdata"}, cpu.resp_rdata, exp_rd);
      check({tag, " table err"}, 32'(cpu.resp_err), 32'(exp_er));
      check({tag, " table beats"}, 32'(nb), 32'(exp_nb));
    end
    got_rdata = cpu.resp_rdata;

    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, " hold resp_valid"}, 32'(cpu.resp_valid), 32'd1);
      check({tag, " hold resp_rdata"}, cpu.resp_rdata, got_rdata);
      check({tag, " hold resp_err"}, 32'(cpu.resp_err), 32'(ill));
      check({tag, " hold req_ready"}, 32'(cpu.req_ready), 32'd0);
    end

    cpu.resp_ready = 1'b1;
    @(posedge clk); #1;
    cpu.resp_ready = 1'b0;
    check({tag, " resp_valid after handshake"}, 32'(cpu.resp_valid), 32'd0);

    if (st && !ill) ref_store(f3, a, wd);
    $display("txn %s: st=%0b f3=%0d addr=0x%08h wdata=0x%08h rdata=0x%08h err=%0b beats=%0d",
             tag, st, f3, a, wd, got_rdata, ill, nb);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit          st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_beats;
    int          hold;
  } vec_t;

  vec_t tbl [$];

  initial begin
    logic [2:0] legal_ld [5];
    logic [2:0] f3;
    logic [31:0] a;
    bit st;

    legal_ld = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
    reset = 1'b1;
    mem_load = 1'b1;
    cpu.req_valid = 1'b0; cpu.req_store = 1'b0; cpu.req_funct3 = 3'b0;
    cpu.req_addr = 32'h0; cpu.req_wdata = 32'h0; cpu.resp_ready = 1'b0;
    cpu_ns.req_valid = 1'b0; cpu_ns.req_store = 1'b0; cpu_ns.req_funct3 = 3'b0;
    cpu_ns.req_addr = 32'h0; cpu_ns.req_wdata = 32'h0; cpu_ns.resp_ready = 1'b0;
    for (int i = 0; i < 256; i++) begin
      init_mem[i] = 8'($urandom);
      ref_mem[i]  = init_mem[i];
    end

    tbl.push_back('{1'b1, F3_W,   32'd4, 32'h0000_00F0, 32'h0,          1'b0, 1, 0});
    tbl.push_back('{1'b0, F3_BU,  32'd4, 32'h0,         32'h0000_00F0,  1'b0, 1, 0});
    tbl.push_back('{1'b1, F3_B,   32'd8, 32'h0000_0080, 32'h0,          1'b0, 1, 0});
    tbl.push_back('{1'b0, F3_B,   32'd8, 32'h0,         32'hFFFF_FF80,  1'b0, 1, 0});
    tbl.push_back('{1'b0, F3_BU,  32'd8, 32'h0,         32'h0000_0080,  1'b0, 1, 0});
    tbl.push_back('{1'b1, F3_H,   32'd8, 32'h0000_8001, 32'h0,          1'b0, 1, 0});
    tbl.push_back('{1'b0, F3_H,   32'd8, 32'h0,         32'hFFFF_8001,  1'b0, 1, 0});
    tbl.push_back('{1'b1, F3_W,   32'd4, 32'h4433_2211, 32'h0,          1'b0, 1, 0});
    tbl.push_back('{1'b1, F3_H,   32'd8, 32'h0000_6655, 32'h0,          1'b0, 1, 0});
    tbl.push_back('{1'b0, F3_W,   32'd5, 32'h0,         32'h5544_3322,  1'b0, 4, 0});
    tbl.push_back('{1'b1, F3_H,   32'd3, 32'h0000_BEEF, 32'h0,          1'b0, 2, 0});
    tbl.push_back('{1'b0, F3_HU,  32'd3, 32'h0,         32'h0000_BEEF,  1'b0, 2, 0});
    tbl.push_back('{1'b0, F3_W,   32'd6, 32'h0,         32'h6655_4433,  1'b0, 4, 0});
    tbl.push_back('{1'b0, 3'b011, 32'd0, 32'h0,         32'h0,          1'b1, 0, 0});
    tbl.push_back('{1'b1, 3'b011, 32'd0, 32'h1234_5678, 32'h0,          1'b1, 0, 0});
    tbl.push_back('{1'b0, F3_W,   32'd4, 32'h0,         32'h4433_22BE,  1'b0, 1, 3});

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    mem_load = 1'b0;
    check("reset resp_valid", 32'(cpu.resp_valid), 32'd0);
    check("reset resp_rdata", cpu.resp_rdata, 32'd0);
    check("reset resp_err", 32'(cpu.resp_err), 32'd0);
    check("reset enables", 32'({dm.read_enable, dm.write_enable}), 32'd0);
    check("reset address", dm.address, 32'd0);
    check("reset write_data", dm.write_data, 32'd0);
    check("reset width", 32'(dm.width), 32'd0);
    check("req_ready during reset", 32'(cpu.req_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("req_ready after reset", 32'(cpu.req_ready), 32'd1);

    // Directed table.
    foreach (tbl[i]) begin
      do_txn(tbl[i].st, tbl[i].f3, tbl[i].addr, tbl[i].wdata, 1'b1, tbl[i].exp_rdata,
             tbl[i].exp_err, tbl[i].exp_beats, tbl[i].hold, $sformatf("tbl%0d", i));
    end

    // Misaligned accesses with splitting disabled are rejected at once.
    for (int k = 0; k < 2; k++) begin
      cpu_ns.req_valid  = 1'b1;
      cpu_ns.req_store  = 1'b0;
      cpu_ns.req_funct3 = (k == 0) ? F3_W : F3_H;
      cpu_ns.req_addr   = (k == 0) ? 32'd2 : 32'd1;
      @(posedge clk); #1;
      cpu_ns.req_valid = 1'b0;
      check("nosplit resp_valid at E0+1", 32'(cpu_ns.resp_valid), 32'd1);
      check("nosplit resp_err", 32'(cpu_ns.resp_err), 32'd1);
      check("nosplit resp_rdata", cpu_ns.resp_rdata, 32'd0);
      check("nosplit enables", 32'({dm_ns.read_enable, dm_ns.write_enable}), 32'd0);
      cpu_ns.resp_ready = 1'b1;
      @(posedge clk); #1;
      cpu_ns.resp_ready = 1'b0;
      check("nosplit enables after", 32'({dm_ns.read_enable, dm_ns.write_enable}), 32'd0);
      $display("txn nosplit%0d: f3=%0d addr=0x%08h rejected", k, cpu_ns.req_funct3, cpu_ns.req_addr);
    end

    // Reset during beat 2 of a misaligned word store at address 1.
    cpu.req_valid  = 1'b1;
    cpu.req_store  = 1'b1;
    cpu.req_funct3 = F3_W;
    cpu.req_addr   = 32'd1;
    cpu.req_wdata  = 32'hA1B2_C3D4;
    @(posedge clk); #1;
    cpu.req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort beat2 address", dm.address, 32'd3);
    check("abort beat2 write_enable", 32'(dm.write_enable), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort enables", 32'({dm.read_enable, dm.write_enable}), 32'd0);
    check("abort resp_valid", 32'(cpu.resp_valid), 32'd0);
    reset = 1'b0;
    #1;
    check("abort req_ready after release", 32'(cpu.req_ready), 32'd1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("abort no response", 32'(cpu.resp_valid), 32'd0);
    end
    // Beats 0..2 reached memory (beat 2 was written on the reset edge).
    ref_mem[1] = 8'hD4;
    ref_mem[2] = 8'hC3;
    ref_mem[3] = 8'hB2;
    $display("txn abort: SW addr=0x00000001 aborted in beat 2");
    do_txn(1'b0, F3_W,  32'd0, 32'h0, 1'b0, 32'h0, 1'b0, 0, 0, "abort_rd0");
    do_txn(1'b0, F3_BU, 32'd4, 32'h0, 1'b0, 32'h0, 1'b0, 0, 0, "abort_rd4");

    // Randomized traffic against the model.
    for (int t = 0; t < 150; t++) begin
      st = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) f3 = 3'($urandom_range(0, 7));
      else if (st) f3 = 3'($urandom_range(0, 2));
      else f3 = legal_ld[$urandom_range(0, 4)];
      if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
      else a = 32'($urandom_range(0, 63));
      do_txn(st, f3, a, $urandom, 1'b0, 32'h0, 1'b0, 0, $urandom_range(0, 2),
             $sformatf("rnd%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
